onehot_encoder_buf: RTL

Inverse of the team's binary-to-one-hot decoder. It accepts a one-hot vector over a valid/ready handshake, encodes it to a binary index, and buffers the result in a 2-entry FIFO toward a valid/ready consumer. It flags and counts vectors that are not one-hot. It sits between the pipeline's one-hot select/grant generators and the register-index and forwarding logic that need binary indices.

---
 rtl/onehot_encoder_buf.sv | 126 ++++++++++++
 1 files changed

// File: rtl/onehot_encoder_buf.sv
// One-hot to binary encoder with a 2-entry output FIFO.
// Vectors are accepted over a valid/ready handshake and encoded to the
// index of their lowest set bit. Each result is buffered as {idx, err}
// toward a valid/ready consumer. Vectors that are not exactly one-hot are
// flagged per entry and counted in a saturating error counter.
module onehot_encoder_buf #(
    parameter int OUTWIDTH = 3,
    parameter int CNTWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [(1<<OUTWIDTH)-1:0] in_onehot,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUTWIDTH-1:0]   out_idx,
    output logic                  out_err,
    output logic [CNTWIDTH-1:0]   err_cnt
);

    localparam int INWIDTH = 1 << OUTWIDTH;

    logic [OUTWIDTH-1:0] enc_idx;
    logic                enc_err;

    // Two-entry storage; the data arrays carry no reset because the
    // outputs are gated by out_valid.
    logic [OUTWIDTH-1:0] idx_q [2];
    logic                err_q [2];

    logic                wptr_q, wptr_d;
    logic                rptr_q, rptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [CNTWIDTH-1:0] err_cnt_q, err_cnt_d;

    logic push;
    logic pop;

    assign in_ready  = (cnt_q < 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_idx = out_valid ? idx_q[rptr_q] : '0;
    assign out_err = out_valid ? err_q[rptr_q] : 1'b0;
    assign err_cnt = err_cnt_q;

    // Encode to the lowest set bit; flag zero or multiple set bits.
    always_comb begin
        enc_idx = '0;
        for (int i = INWIDTH - 1; i >= 0; i--) begin
            if (in_onehot[i]) begin
                enc_idx = OUTWIDTH'(i);
            end
        end
        // v & (v-1) clears the lowest set bit, so any remainder means >1 bits.
        enc_err = (in_onehot == '0) ||
                  ((in_onehot & (in_onehot - INWIDTH'(1))) != '0);
    end

    // Next-state for pointers, occupancy and the saturating error counter.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wptr_d = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (push && enc_err && (err_cnt_q != {CNTWIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNTWIDTH'(1);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            cnt_q     <= 2'd0;
            err_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Capture the encoded entry at the write pointer on every push.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[wptr_q] <= enc_idx;
            err_q[wptr_q] <= enc_err;
        end
    end

`ifdef SVA_ON
    a_cnt_max : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= 2'd2);

    a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_idx) && $stable(out_err)));

    a_onehot_no_err : assert property (@(posedge clk) disable iff (!rst_n)
        (push && $onehot(in_onehot)) |-> !enc_err);

    c_full : cover property (@(posedge clk) disable iff (!rst_n)
        cnt_q == 2'd2);

    for (genvar g = 0; g < INWIDTH; g++) begin : g_cov_idx
        c_idx : cover property (@(posedge clk) disable iff (!rst_n)
            pop && (out_idx == OUTWIDTH'(g)));
    end
`endif

endmodule
